pool_relu_writer: RTL and testbench
===================================

POOL_RELU_WRITER -- requirements
Module: pool_relu_writer

Interface
REQ-001 Parameter IN_W, default 24: conv output row width in pixels; SHALL be even.
REQ-002 Parameter IN_H, default 24: conv output rows per channel; SHALL be even.
REQ-003 Parameter CH, default 20: channels per job.
REQ-004 Parameter DATA_WIDTH, default 8: signed pixel width.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 srstn  in  1  reset, asynchronous, active-low.
REQ-007 pool_start  in  1  one-cycle job start pulse.
REQ-008 in_valid  in  1  conv pixel valid.
REQ-009 in_data  in  DATA_WIDTH  signed conv pixel, raster order (col fastest, then row, then channel).
REQ-010 in_ready  out  1  pixel accepted when in_valid && in_ready.
REQ-011 sram_write_enable  out  1  active-low SRAM write strobe.
REQ-012 sram_bytemask  out  4  byte enables, 1 = write; bit3 = wdata[31:24].
REQ-013 sram_waddr  out  10  word address.
REQ-014 sram_wdata  out  32  four packed pooled bytes.
REQ-015 pool_busy  out  1  high in RUN and FLUSH.
REQ-016 pool_finish  out  1  one-cycle pulse on job completion.

Function
REQ-017 FSM states IDLE, RUN, FLUSH, DONE; IDLE->RUN on pool_start; RUN->FLUSH on acceptance of last pixel of last channel; FLUSH->DONE after final write issued; DONE->IDLE next cycle with pool_finish=1 for that cycle only.
REQ-018 pool_start outside IDLE SHALL be ignored.
REQ-019 in_ready SHALL be 1 only in RUN; in_valid outside RUN is ignored.
REQ-020 Counters col (0..IN_W-1), row (0..IN_H-1), ch (0..CH-1) advance only on accepted pixels; col wraps into row, row wraps into ch.
REQ-021 Even row: horizontal max of each pixel pair stored in a line buffer of IN_W/2 entries.
REQ-022 Odd row, odd col: pooled = max(line_buf[col/2], max(pair)), then ReLU: negative -> 0; result unsigned 8 bits (range 0..127).
REQ-023 Signed comparison throughout; -128 and 127 SHALL compare correctly.
REQ-024 Pooled bytes packed MSB-first: first pooled pixel of a word in [31:24].
REQ-025 Word written (sram_write_enable=0, bytemask=4'b1111) in the cycle after its 4th pooled byte is produced; registered output, latency 1 cycle.
REQ-026 If a pooled row of a channel ends on a partial word (IN_W/2 per row times rows not multiple of 4 at channel end), partial word SHALL be written at channel end with bytemask covering only filled bytes, remaining bytes 0.
REQ-027 Word addresses per channel: ch*ceil((IN_W/2)*(IN_H/2)/4) + word index; defaults give 36 words/channel, addresses 0..719.
REQ-028 sram_write_enable SHALL be 1 and bytemask 0 in every cycle without a write.
REQ-029 Gaps in in_valid SHALL not change written data or addresses, only timing.

Reset
REQ-030 On srstn low, asynchronously: state IDLE, all counters 0, line buffer content don't-care, sram_write_enable=1, sram_bytemask=0, sram_waddr=0, sram_wdata=0, in_ready=0, pool_busy=0, pool_finish=0.
REQ-031 Reset mid-job SHALL abandon the job; no further writes until a new pool_start, which restarts at address 0.

Structure
REQ-032 FSM state encoding and words-per-channel constant SHALL live in the shared lenet package.
REQ-033 One sub-module, pool_line_buf (IN_W/2 x DATA_WIDTH register array, one write/one read port), is natural; rest in pool_relu_writer.

Verification
REQ-034 Defaults, all pixels 5, in_valid constant -> 720 writes, waddr 0..719 ascending, each wdata 0x05050505, bytemask 4'hF, one pool_finish.
REQ-035 All pixels -3 -> 720 writes of 0x00000000.
REQ-036 Channel 0 all 0 except (row1,col1)=100 -> waddr 0 wdata 0x64000000, all other words 0.
REQ-037 Window {-128,127,-1,0} in every 2x2 block -> every wdata 0x7F7F7F7F.
REQ-038 Scenario REQ-034 with in_valid toggling every cycle -> identical write sequence, ~2x duration.
REQ-039 srstn pulsed low after 300 pixels, then pool_start with REQ-034 stimulus -> outputs at reset values during reset, then full correct 720-write sequence starting at waddr 0.

Source files
------------

// File: rtl/pool_relu_writer_pkg.sv
// rtl/pool_relu_writer_pkg.sv - shared FSM encoding and word-layout helpers for the pooling writer
package pool_relu_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } pool_state_t;

  localparam int WORDS_PER_CH = 36;

  // Pooled bytes of one channel, rounded up to whole 32-bit words.
  function automatic int words_per_ch(input int in_w, input int in_h);
    return ((in_w / 2) * (in_h / 2) + 3) / 4;
  endfunction

endpackage

// File: rtl/pool_relu_writer_line_buf.sv
// rtl/pool_relu_writer_line_buf.sv - half-row buffer of horizontal pair maxima
module pool_line_buf #(
  parameter int DEPTH      = 12,
  parameter int DATA_WIDTH = 8,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pool_relu_writer.sv
// rtl/pool_relu_writer.sv - 2x2 max-pool + ReLU of a raster pixel stream, packed into 32-bit SRAM words
module pool_relu_writer
  import pool_relu_writer_pkg::*;
#(
  parameter int IN_W       = 24,
  parameter int IN_H       = 24,
  parameter int CH         = 20,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  pool_start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  sram_write_enable,
  output logic [3:0]            sram_bytemask,
  output logic [9:0]            sram_waddr,
  output logic [31:0]           sram_wdata,
  output logic                  pool_busy,
  output logic                  pool_finish
);

  localparam int HALF_W = IN_W / 2;
  localparam int CW     = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int RW     = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int CHW    = (CH > 1) ? $clog2(CH) : 1;
  localparam int LBW    = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int WPC    = words_per_ch(IN_W, IN_H);

  function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  pool_state_t r_state, w_next_state;

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [CHW-1:0]        r_ch;
  logic [DATA_WIDTH-1:0] r_first;
  logic [31:0]           r_pack;
  logic [1:0]            r_byte_cnt;
  logic [9:0]            r_word_idx;
  logic                  r_we_n;
  logic [3:0]            r_mask;
  logic [9:0]            r_waddr;
  logic [31:0]           r_wdata;

  logic                  w_accept, w_last_col, w_last_row, w_last_ch, w_last_pix, w_chan_end;
  logic                  w_lb_we, w_pooled_valid, w_word_full;
  logic [LBW-1:0]        w_lb_addr;
  logic [DATA_WIDTH-1:0] w_lb_rdata, w_pair_max, w_pool;
  logic [7:0]            w_relu;
  logic [31:0]           w_word;
  logic [3:0]            w_mask;
  logic [9:0]            w_addr;

  assign w_accept       = in_valid && in_ready;
  assign w_last_col     = (r_col == CW'(IN_W - 1));
  assign w_last_row     = (r_row == RW'(IN_H - 1));
  assign w_last_ch      = (r_ch == CHW'(CH - 1));
  assign w_chan_end     = w_accept && w_last_col && w_last_row;
  assign w_last_pix     = w_chan_end && w_last_ch;
  assign w_lb_addr      = LBW'(r_col >> 1);
  assign w_pair_max     = smax(r_first, in_data);
  assign w_lb_we        = w_accept && !r_row[0] && r_col[0];
  assign w_pooled_valid = w_accept && r_row[0] && r_col[0];
  assign w_pool         = smax(w_lb_rdata, w_pair_max);
  assign w_relu         = w_pool[DATA_WIDTH-1] ? 8'd0 : 8'(w_pool);
  assign w_word         = r_pack | ({w_relu, 24'd0} >> (8 * r_byte_cnt));
  assign w_word_full    = (r_byte_cnt == 2'd3) || w_chan_end;
  assign w_addr         = 10'(32'(r_ch) * WPC + 32'(r_word_idx));

  always_comb begin
    w_mask = 4'b1111;
    case (r_byte_cnt)
      2'd0:    w_mask = 4'b1000;
      2'd1:    w_mask = 4'b1100;
      2'd2:    w_mask = 4'b1110;
      default: w_mask = 4'b1111;
    endcase
  end

  pool_line_buf #(
    .DEPTH      (HALF_W),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (LBW)
  ) u_line_buf (
    .clk     (clk),
    .i_we    (w_lb_we),
    .i_waddr (w_lb_addr),
    .i_wdata (w_pair_max),
    .i_raddr (w_lb_addr),
    .o_rdata (w_lb_rdata)
  );

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (pool_start) w_next_state = ST_RUN;
      ST_RUN:   if (w_last_pix) w_next_state = ST_FLUSH;
      ST_FLUSH: w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == ST_RUN);
    pool_busy   = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    pool_finish = (r_state == ST_DONE);
  end

  // Raster counters; they wrap back to zero naturally at job end.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_col   <= '0;
      r_row   <= '0;
      r_ch    <= '0;
      r_first <= '0;
    end else if (w_accept) begin
      r_col <= w_last_col ? '0 : r_col + 1'b1;
      if (w_last_col) r_row <= w_last_row ? '0 : r_row + 1'b1;
      if (w_last_col && w_last_row) r_ch <= w_last_ch ? '0 : r_ch + 1'b1;
      if (!r_col[0]) r_first <= in_data;
    end
  end

  // Byte packer; a channel end flushes whatever bytes are pending.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_pack     <= '0;
      r_byte_cnt <= '0;
      r_word_idx <= '0;
      r_we_n     <= 1'b1;
      r_mask     <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_we_n <= 1'b1;
      r_mask <= '0;
      if (r_state == ST_IDLE && pool_start) begin
        r_pack     <= '0;
        r_byte_cnt <= '0;
        r_word_idx <= '0;
      end else if (w_pooled_valid) begin
        if (w_word_full) begin
          r_we_n     <= 1'b0;
          r_mask     <= w_mask;
          r_waddr    <= w_addr;
          r_wdata    <= w_word;
          r_pack     <= '0;
          r_byte_cnt <= '0;
          r_word_idx <= w_chan_end ? '0 : r_word_idx + 1'b1;
        end else begin
          r_pack     <= w_word;
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
      end
    end
  end

  assign sram_write_enable = r_we_n;
  assign sram_bytemask     = r_mask;
  assign sram_waddr        = r_waddr;
  assign sram_wdata        = r_wdata;

endmodule

// File: tb/tb_pool_relu_writer.sv
// tb/tb_pool_relu_writer.sv - directed self-checking bench for pool_relu_writer
module tb_pool_relu_writer;

  localparam int NPIX = 24 * 24 * 20;

  logic clk = 1'b0;
  logic srstn = 1'b0;
  always #5 clk = ~clk;

  logic       pool_start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, sram_write_enable, pool_busy, pool_finish;
  logic [3:0] sram_bytemask;
  logic [9:0] sram_waddr;
  logic [31:0] sram_wdata;

  pool_relu_writer dut (
    .clk(clk), .srstn(srstn), .pool_start(pool_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .sram_write_enable(sram_write_enable),
    .sram_bytemask(sram_bytemask), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
    .pool_busy(pool_busy), .pool_finish(pool_finish)
  );

  logic       s_start = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready, s_we_n, s_busy, s_finish;
  logic [3:0] s_mask;
  logic [9:0] s_waddr;
  logic [31:0] s_wdata;

  pool_relu_writer #(.IN_W(6), .IN_H(6), .CH(2), .DATA_WIDTH(8)) dut_small (
    .clk(clk), .srstn(srstn), .pool_start(s_start), .in_valid(s_valid),
    .in_data(s_data), .in_ready(s_ready), .sram_write_enable(s_we_n),
    .sram_bytemask(s_mask), .sram_waddr(s_waddr), .sram_wdata(s_wdata),
    .pool_busy(s_busy), .pool_finish(s_finish)
  );

  int n_assert = 0;
  int n_fail = 0;

  logic [9:0]  m_addr [0:4095];
  logic [31:0] m_data [0:4095];
  logic [3:0]  m_mask [0:4095];
  int wr_n = 0, fin_n = 0;
  logic [9:0]  sm_addr [0:63];
  logic [31:0] sm_data [0:63];
  logic [3:0]  sm_mask [0:63];
  int s_wr_n = 0, s_fin_n = 0;

  always @(negedge clk) begin
    if (!sram_write_enable) begin
      if (wr_n < 4096) begin
        m_addr[wr_n] <= sram_waddr;
        m_data[wr_n] <= sram_wdata;
        m_mask[wr_n] <= sram_bytemask;
      end
      wr_n <= wr_n + 1;
    end
    if (pool_finish) fin_n <= fin_n + 1;
    if (!s_we_n) begin
      if (s_wr_n < 64) begin
        sm_addr[s_wr_n] <= s_waddr;
        sm_data[s_wr_n] <= s_wdata;
        sm_mask[s_wr_n] <= s_mask;
      end
      s_wr_n <= s_wr_n + 1;
    end
    if (s_finish) s_fin_n <= s_fin_n + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: all 5; mode 1: ch0 (1,1)=100 else 0; mode 2: {-128,127,-1,0} windows
  function automatic logic [7:0] pix(input int mode, input int idx);
    int c, r, ch;
    c = idx % 24;
    r = (idx / 24) % 24;
    ch = idx / 576;
    case (mode)
      0: return 8'd5;
      1: return (ch == 0 && r == 1 && c == 1) ? 8'd100 : 8'd0;
      default: begin
        if (r % 2 == 0) return (c % 2 == 0) ? 8'h80 : 8'h7F;
        else            return (c % 2 == 0) ? 8'hFF : 8'h00;
      end
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input int mode, input int i);
    case (mode)
      0: return 32'h05050505;
      1: return (i == 0) ? 32'h64000000 : 32'h00000000;
      default: return 32'h7F7F7F7F;
    endcase
  endfunction

  task automatic run_job(input int mode, input bit toggle, input int stop_after,
                         output int cycles);
    int idx, cyc;
    bit acc, tog;
    idx = 0; cyc = 0; tog = 1'b1;
    @(negedge clk) pool_start = 1'b1;
    @(negedge clk) pool_start = 1'b0;
    chk("busy_in_run", {63'd0, pool_busy}, 64'd1);
    while (idx < NPIX && idx < stop_after && cyc < 40000) begin
      in_valid = toggle ? tog : 1'b1;
      tog = ~tog;
      in_data = pix(mode, idx);
      acc = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    cycles = cyc;
    if (stop_after >= NPIX) chk("pixel_budget", 64'(cyc < 40000), 64'd1);
  endtask

  task automatic check_job(input string tag, input int mode, input int base, input int fbase);
    int n, bad, t;
    t = 0;
    while (fin_n == fbase && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    n = wr_n - base;
    chk({tag, "_nwrites"}, 64'(n), 64'd720);
    chk({tag, "_nfinish"}, 64'(fin_n - fbase), 64'd1);
    bad = -1;
    for (int i = 0; i < 720 && i < n; i++) begin
      if (bad < 0 && (m_addr[base+i] !== 10'(i) || m_data[base+i] !== exp_word(mode, i) ||
                      m_mask[base+i] !== 4'hF)) bad = i;
    end
    if (bad < 0) bad = 0;
    chk({tag, "_addr"}, 64'(m_addr[base+bad]), 64'(bad));
    chk({tag, "_data"}, 64'(m_data[base+bad]), 64'(exp_word(mode, bad)));
    chk({tag, "_mask"}, 64'(m_mask[base+bad]), 64'hF);
  endtask

  initial begin
    int base, fbase, cyc, sidx, t;
    logic [9:0]  s_exp_addr [0:5];
    logic [31:0] s_exp_data [0:5];
    logic [3:0]  s_exp_mask [0:5];

    repeat (3) @(negedge clk);
    chk("rst_we_n", {63'd0, sram_write_enable}, 64'd1);
    chk("rst_mask", 64'(sram_bytemask), 64'd0);
    chk("rst_waddr", 64'(sram_waddr), 64'd0);
    chk("rst_wdata", 64'(sram_wdata), 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_busy_finish", {62'd0, pool_busy, pool_finish}, 64'd0);
    srstn = 1'b1;

    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_ready", {63'd0, in_ready}, 64'd0);
    chk("idle_nowrite", 64'(wr_n), 64'd0);
    in_valid = 1'b0;

    base = wr_n; fbase = fin_n;
    run_job(0, 1'b0, NPIX, cyc);
    chk("const_cycles", 64'(cyc), 64'(NPIX));
    check_job("all5", 0, base, fbase);

    base = wr_n; fbase = fin_n;
    run_job(1, 1'b0, NPIX, cyc);
    check_job("single100", 1, base, fbase);

    base = wr_n; fbase = fin_n;
    run_job(2, 1'b0, NPIX, cyc);
    check_job("minmax", 2, base, fbase);

    base = wr_n; fbase = fin_n;
    run_job(0, 1'b1, NPIX, cyc);
    chk("toggle_cycles", 64'(cyc >= 23000 && cyc <= 23100), 64'd1);
    check_job("toggle", 0, base, fbase);

    run_job(0, 1'b0, 300, cyc);
    srstn = 1'b0;
    #1;
    chk("midrst_we_n", {63'd0, sram_write_enable}, 64'd1);
    chk("midrst_mask", 64'(sram_bytemask), 64'd0);
    chk("midrst_addr_data", {22'd0, sram_waddr, sram_wdata}, 64'd0);
    chk("midrst_flags", {61'd0, in_ready, pool_busy, pool_finish}, 64'd0);
    repeat (2) @(negedge clk);
    srstn = 1'b1;
    @(negedge clk);
    base = wr_n; fbase = fin_n;
    run_job(0, 1'b0, NPIX, cyc);
    check_job("after_rst", 0, base, fbase);

    s_exp_addr = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5};
    s_exp_data = '{32'h07090B13, 32'h15171F21, 32'h23000000, 32'h0, 32'h0, 32'h0};
    s_exp_mask = '{4'hF, 4'hF, 4'h8, 4'hF, 4'hF, 4'h8};
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    sidx = 0; t = 0;
    while (sidx < 72 && t < 500) begin
      bit acc;
      s_valid = 1'b1;
      s_data = (sidx < 36) ? 8'(sidx) : 8'hFD;
      if (sidx == 20) s_start = 1'b1;
      acc = s_valid && s_ready;
      @(negedge clk);
      s_start = 1'b0;
      t++;
      if (acc) sidx++;
    end
    s_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("small_nwrites", 64'(s_wr_n), 64'd6);
    chk("small_nfinish", 64'(s_fin_n), 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("small_addr%0d", i), 64'(sm_addr[i]), 64'(s_exp_addr[i]));
      chk($sformatf("small_data%0d", i), 64'(sm_data[i]), 64'(s_exp_data[i]));
      chk($sformatf("small_mask%0d", i), 64'(sm_mask[i]), 64'(s_exp_mask[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
